// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed data memory for the multicycle MIPS datapath.
// Separate read/write buses, byte/half/word access with optional sign
// extension, programmable wait states and a Req/Ready handshake.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (flag misaligned/reserved
// accesses with Err and suppress them; otherwise low address bits are masked).
//
// Handshake: Req is sampled only in IDLE; the request fields are latched on
// that accept edge. Ready is a one-cycle pulse in RESP, with RData (reads) and
// Err valid in the same cycle. Req while Busy is dropped, never queued.
module data_mem_ctrl #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 1,
    parameter     INIT_FILE   = ""
) (
    input  logic              CLK,
    input  logic              Rst,
    input  logic              Req,
    input  logic              WE,
    input  logic [1:0]        Size,
    input  logic              SignExt,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       WData,
    output logic [31:0]       RData,
    output logic              Ready,
    output logic              Busy,
    output logic              Err,
    output logic [1:0]        o_dbg_state
);

    localparam int          DEPTH     = 2 ** (ADDR_W - 2);
    localparam int          WAIT_M1   = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0]  WAIT_INIT = WAIT_M1[3:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_cnt;
    logic               r_we;
    logic [1:0]         r_size;
    logic               r_sext;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic [31:0]        r_mem [0:DEPTH-1];

    logic               w_accept;
    logic               w_commit;
    logic               w_a_we;
    logic [1:0]         w_a_size;
    logic               w_a_sext;
    logic [ADDR_W-1:0]  w_a_addr;
    logic [31:0]        w_a_wdata;
    logic [ADDR_W-3:0]  w_idx;
    logic [1:0]         w_lane;
    logic               w_bad;
    logic [31:0]        w_old;
    logic [31:0]        w_wr_word;
    logic [31:0]        w_rd_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;

    assign w_accept = (r_state == S_IDLE) && Req;
    // The storage access happens on the edge that enters RESP.
    assign w_commit = (w_next == S_RESP) && (r_state != S_RESP);

    // With zero wait states the commit edge is the accept edge, so the access
    // fields come straight from the inputs in IDLE and from the latches later.
    assign w_a_we    = (r_state == S_IDLE) ? WE      : r_we;
    assign w_a_size  = (r_state == S_IDLE) ? Size    : r_size;
    assign w_a_sext  = (r_state == S_IDLE) ? SignExt : r_sext;
    assign w_a_addr  = (r_state == S_IDLE) ? Addr    : r_addr;
    assign w_a_wdata = (r_state == S_IDLE) ? WData   : r_wdata;

    assign w_idx  = w_a_addr[ADDR_W-1:2];
    assign w_lane = w_a_addr[1:0];
    assign w_old  = r_mem[w_idx];

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_bad = ((w_a_size == 2'b01) && w_lane[0]) ||
                   ((w_a_size == 2'b10) && (w_lane != 2'b00)) ||
                   (w_a_size == 2'b11);
`else
    assign w_bad = 1'b0;
`endif

    // Next-state logic for IDLE -> (WAIT) -> RESP -> IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (Req) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Merge write data into the addressed lanes; size 11 falls through to word.
    always_comb begin
        w_wr_word = w_old;
        case (w_a_size)
            2'b00: w_wr_word[{w_lane, 3'b000} +: 8] = w_a_wdata[7:0];
            2'b01: begin
                if (w_lane[1]) w_wr_word[31:16] = w_a_wdata[15:0];
                else           w_wr_word[15:0]  = w_a_wdata[15:0];
            end
            default: w_wr_word = w_a_wdata;
        endcase
    end

    // Extract and extend the read lane(s).
    always_comb begin
        w_byte    = w_old[{w_lane, 3'b000} +: 8];
        w_half    = w_lane[1] ? w_old[31:16] : w_old[15:0];
        w_rd_word = w_old;
        case (w_a_size)
            2'b00: w_rd_word = w_a_sext ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
            2'b01: w_rd_word = w_a_sext ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
            default: w_rd_word = w_old;
        endcase
    end

    // State, wait counter, request latches, read data and error flag.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_sext  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= WE;
                r_size  <= Size;
                r_sext  <= SignExt;
                r_addr  <= Addr;
                r_wdata <= WData;
                r_cnt   <= WAIT_INIT;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_err <= w_bad;
                if (!w_a_we && !w_bad) r_rdata <= w_rd_word;
            end
        end
    end

    // Storage array: never cleared by reset; a reset on the commit edge aborts.
    always_ff @(posedge CLK) begin
        if (!Rst && w_commit && w_a_we && !w_bad) r_mem[w_idx] <= w_wr_word;
    end

    assign RData       = r_rdata;
    assign Ready       = (r_state == S_RESP);
    assign Busy        = (r_state != S_IDLE);
    assign Err         = (r_state == S_RESP) && r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed testbench for data_mem_ctrl: one instance with one wait state and
// one with none (throughput scenario). Both share all inputs except Req.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req1, req0;
  logic        we, sext;
  logic [1:0]  size;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata1, rdata0;
  logic        ready1, busy1, err1, ready0, busy0, err0;
  logic [1:0]  dbg1, dbg0;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  data_mem_ctrl #(.ADDR_W(12), .WAIT_CYCLES(1)) u_dut (
    .CLK(clk), .Rst(rst), .Req(req1), .WE(we), .Size(size), .SignExt(sext),
    .Addr(addr), .WData(wdata), .RData(rdata1), .Ready(ready1), .Busy(busy1),
    .Err(err1), .o_dbg_state(dbg1)
  );

  data_mem_ctrl #(.ADDR_W(12), .WAIT_CYCLES(0)) u_dut0 (
    .CLK(clk), .Rst(rst), .Req(req0), .WE(we), .Size(size), .SignExt(sext),
    .Addr(addr), .WData(wdata), .RData(rdata0), .Ready(ready0), .Busy(busy0),
    .Err(err0), .o_dbg_state(dbg0)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Driver: one complete access on the selected instance. Returns the data and
  // Err seen in the Ready cycle, accept-edge-to-Ready latency (-1 on timeout),
  // whether Ready dropped after one cycle, and whether Busy stayed high.
  task automatic do_access(input bit d0, input bit we_i, input logic [1:0] size_i,
                           input bit sext_i, input logic [11:0] addr_i,
                           input logic [31:0] wdata_i, output logic [31:0] rdata_o,
                           output int lat_o, output logic err_o,
                           output bit pulse_ok_o, output bit busy_ok_o);
    @(negedge clk);
    we = we_i; size = size_i; sext = sext_i; addr = addr_i; wdata = wdata_i;
    if (d0) req0 = 1'b1; else req1 = 1'b1;
    @(posedge clk);
    lat_o = 1;
    busy_ok_o = 1'b1;
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    while (!(d0 ? ready0 : ready1) && lat_o < 20) begin
      if (!(d0 ? busy0 : busy1)) busy_ok_o = 1'b0;
      @(posedge clk);
      lat_o++;
      @(negedge clk);
    end
    if (!(d0 ? ready0 : ready1)) begin
      lat_o = -1;
      rdata_o = 32'hx;
      err_o = 1'bx;
      pulse_ok_o = 1'b0;
    end else begin
      if (!(d0 ? busy0 : busy1)) busy_ok_o = 1'b0;
      rdata_o = d0 ? rdata0 : rdata1;
      err_o = d0 ? err0 : err1;
      @(negedge clk);
      pulse_ok_o = !(d0 ? ready0 : ready1) && !(d0 ? busy0 : busy1) && !(d0 ? err0 : err1);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req1 = 1'b0; req0 = 1'b0; we = 1'b0; size = 2'b10;
    sext = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (rdata1 !== 32'd0 || ready1 !== 1'b0 || busy1 !== 1'b0 || err1 !== 1'b0)
      $display("FAIL reset_dut1: rdata=%h ready=%b busy=%b err=%b, required 0/0/0/0",
               rdata1, ready1, busy1, err1);
    n_checks++;
    if (rdata0 !== 32'd0 || ready0 !== 1'b0 || busy0 !== 1'b0 || err0 !== 1'b0)
      $display("FAIL reset_dut0: rdata=%h ready=%b busy=%b err=%b, required 0/0/0/0",
               rdata0, ready0, busy0, err0);
    if (n_errors == 0 && (rdata1 !== 32'd0 || busy1 !== 1'b0 || rdata0 !== 32'd0 || busy0 !== 1'b0))
      n_errors++;
    if (ready1 !== 1'b0 || err1 !== 1'b0 || ready0 !== 1'b0 || err0 !== 1'b0) n_errors++;
  endtask

  task automatic test_word;
    logic [31:0] rd; int lat; logic er; bit p, b;
    do_access(0, 1, 2'b10, 0, 12'h010, 32'hDEADBEEF, rd, lat, er, p, b);
    n_checks++;
    if (lat !== 2 || !p || !b || er !== 1'b0) begin
      n_errors++;
      $display("FAIL word_write_handshake: lat=%0d pulse=%b busy=%b err=%b, required 2/1/1/0", lat, p, b, er);
    end
    exp_q.push_back(32'hDEADBEEF);
    do_access(0, 0, 2'b10, 0, 12'h010, 32'h0, rd, lat, er, p, b);
    n_checks++;
    if (lat !== 2 || !p || !b) begin
      n_errors++;
      $display("FAIL word_read_handshake: lat=%0d pulse=%b busy=%b, required 2/1/1", lat, p, b);
    end
    n_checks++;
    if (rd !== exp_q.pop_front()) begin
      n_errors++;
      $display("FAIL word_read_data: got %h, required deadbeef", rd);
    end
  endtask

  task automatic test_byte;
    logic [31:0] rd; int lat; logic er; bit p, b;
    logic [31:0] exp_v;
    do_access(0, 1, 2'b10, 0, 12'h010, 32'h00000000, rd, lat, er, p, b);
    do_access(0, 1, 2'b00, 0, 12'h013, 32'h12345680, rd, lat, er, p, b);
    exp_q.push_back(32'hFFFFFF80);
    exp_q.push_back(32'h00000080);
    exp_q.push_back(32'h80000000);
    do_access(0, 0, 2'b00, 1, 12'h013, 32'h0, rd, lat, er, p, b);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (rd !== exp_v || er !== 1'b0) begin
      n_errors++;
      $display("FAIL byte_read_sext: got %h err=%b, required %h err=0", rd, er, exp_v);
    end
    do_access(0, 0, 2'b00, 0, 12'h013, 32'h0, rd, lat, er, p, b);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (rd !== exp_v) begin
      n_errors++;
      $display("FAIL byte_read_zext: got %h, required %h", rd, exp_v);
    end
    do_access(0, 0, 2'b10, 0, 12'h010, 32'h0, rd, lat, er, p, b);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (rd !== exp_v) begin
      n_errors++;
      $display("FAIL byte_word_view: got %h, required %h", rd, exp_v);
    end
    // A write completes without touching RData.
    do_access(0, 1, 2'b00, 0, 12'h011, 32'h000000AB, rd, lat, er, p, b);
    n_checks++;
    if (rd !== 32'h80000000) begin
      n_errors++;
      $display("FAIL rdata_hold_on_write: got %h, required 80000000", rd);
    end
  endtask

  task automatic test_half;
    logic [31:0] rd; int lat; logic er; bit p, b;
    do_access(0, 1, 2'b10, 0, 12'h020, 32'h00000000, rd, lat, er, p, b);
    do_access(0, 1, 2'b01, 0, 12'h022, 32'hFFFF1234, rd, lat, er, p, b);
    do_access(0, 0, 2'b10, 0, 12'h020, 32'h0, rd, lat, er, p, b);
    n_checks++;
    if (rd !== 32'h12340000) begin
      n_errors++;
      $display("FAIL half_word_view: got %h, required 12340000", rd);
    end
    do_access(0, 0, 2'b01, 0, 12'h020, 32'h0, rd, lat, er, p, b);
    n_checks++;
    if (rd !== 32'h00000000) begin
      n_errors++;
      $display("FAIL half_low_read: got %h, required 00000000", rd);
    end
    do_access(0, 1, 2'b01, 0, 12'h020, 32'h0000BEEF, rd, lat, er, p, b);
    do_access(0, 0, 2'b01, 1, 12'h020, 32'h0, rd, lat, er, p, b);
    n_checks++;
    if (rd !== 32'hFFFFBEEF) begin
      n_errors++;
      $display("FAIL half_read_sext: got %h, required ffffbeef", rd);
    end
    do_access(0, 0, 2'b01, 1, 12'h022, 32'h0, rd, lat, er, p, b);
    n_checks++;
    if (rd !== 32'h00001234) begin
      n_errors++;
      $display("FAIL half_upper_read: got %h, required 00001234", rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; int lat; logic er; bit p, b;
    logic [5:0] pat;
    do_access(1, 1, 2'b10, 0, 12'h048, 32'hAAAAAAAA, rd, lat, er, p, b);
    n_checks++;
    if (lat !== 1 || !p) begin
      n_errors++;
      $display("FAIL zero_wait_latency: lat=%0d pulse=%b, required 1/1", lat, p);
    end
    // Req held high for six cycles: accepts on cycles 1, 3, 5 only.
    @(negedge clk);
    we = 1'b1; size = 2'b10; sext = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      addr = 12'h040 + 12'(4 * k);
      wdata = 32'(k);
      req0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      pat[k-1] = ready0;
    end
    req0 = 1'b0;
    n_checks++;
    if (pat !== 6'b010101) begin
      n_errors++;
      $display("FAIL b2b_ready_pattern: got %b, required 010101", pat);
    end
    exp_q.push_back(32'd1);
    exp_q.push_back(32'hAAAAAAAA);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd5);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a;
      logic [31:0] exp_v;
      a = (k == 3) ? 32'h054 : 32'h044 + 32'(4 * k);
      do_access(1, 0, 2'b10, 0, a[11:0], 32'h0, rd, lat, er, p, b);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rd !== exp_v) begin
        n_errors++;
        $display("FAIL b2b_readback_%0h: got %h, required %h", a, rd, exp_v);
      end
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd; int lat; logic er; bit p, b;
    do_access(0, 1, 2'b10, 0, 12'h030, 32'h11111111, rd, lat, er, p, b);
    @(negedge clk);
    we = 1'b1; size = 2'b10; addr = 12'h030; wdata = 32'h22222222; req1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req1 = 1'b0;
    n_checks++;
    if (busy1 !== 1'b1 || ready1 !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_in_wait: busy=%b ready=%b, required 1/0", busy1, ready1);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (ready1 !== 1'b0 || busy1 !== 1'b0 || rdata1 !== 32'd0) begin
      n_errors++;
      $display("FAIL abort_after_reset: ready=%b busy=%b rdata=%h, required 0/0/0", ready1, busy1, rdata1);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (ready1 !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_no_late_ready: ready=%b, required 0", ready1);
    end
    do_access(0, 0, 2'b10, 0, 12'h030, 32'h0, rd, lat, er, p, b);
    n_checks++;
    if (rd !== 32'h11111111) begin
      n_errors++;
      $display("FAIL abort_no_write: got %h, required 11111111", rd);
    end
    // Reset and Req together: reset wins.
    @(negedge clk);
    rst = 1'b1; req1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy1 !== 1'b0 || ready1 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_beats_req: busy=%b ready=%b, required 0/0", busy1, ready1);
    end
  endtask

  task automatic test_misaligned;
    logic [31:0] rd; int lat; logic er; bit p, b;
    do_access(0, 1, 2'b10, 0, 12'h030, 32'h33333333, rd, lat, er, p, b);
    do_access(0, 1, 2'b10, 0, 12'h031, 32'hCAFEF00D, rd, lat, er, p, b);
`ifdef DMEM_ALIGN_CHECK_EN
    n_checks++;
    if (er !== 1'b1 || lat !== 2 || !p) begin
      n_errors++;
      $display("FAIL misalign_err: err=%b lat=%0d pulse=%b, required 1/2/1", er, lat, p);
    end
    do_access(0, 0, 2'b10, 0, 12'h030, 32'h0, rd, lat, er, p, b);
    n_checks++;
    if (rd !== 32'h33333333 || er !== 1'b0) begin
      n_errors++;
      $display("FAIL misalign_no_write: got %h err=%b, required 33333333 err=0", rd, er);
    end
    do_access(0, 0, 2'b01, 0, 12'h033, 32'h0, rd, lat, er, p, b);
    n_checks++;
    if (rd !== 32'h33333333 || er !== 1'b1) begin
      n_errors++;
      $display("FAIL misalign_read_hold: got %h err=%b, required 33333333 err=1", rd, er);
    end
`else
    n_checks++;
    if (er !== 1'b0 || lat !== 2 || !p) begin
      n_errors++;
      $display("FAIL misalign_err: err=%b lat=%0d pulse=%b, required 0/2/1", er, lat, p);
    end
    do_access(0, 0, 2'b10, 0, 12'h030, 32'h0, rd, lat, er, p, b);
    n_checks++;
    if (rd !== 32'hCAFEF00D) begin
      n_errors++;
      $display("FAIL misalign_masked_write: got %h, required cafef00d", rd);
    end
    do_access(0, 1, 2'b11, 0, 12'h032, 32'h0BADCAFE, rd, lat, er, p, b);
    do_access(0, 0, 2'b10, 0, 12'h030, 32'h0, rd, lat, er, p, b);
    n_checks++;
    if (rd !== 32'h0BADCAFE) begin
      n_errors++;
      $display("FAIL size11_as_word: got %h, required 0badcafe", rd);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_back_to_back();
    test_reset_abort();
    test_misaligned();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound in case a wait never completes.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
